// File: rtl/branch_pc_unit.sv
// Fetch-stage program counter with taken-branch / register-jump redirect and a one-cycle flush.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN (adds the misalign port).
module branch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchValid,
  input  logic        branchCond,
  input  logic [15:0] branchBase,
  input  logic [15:0] shiftedOut,
  input  logic        jumpReg,
  input  logic [15:0] jumpTarget,
  output logic [15:0] pc,
  output logic [15:0] pcPlus2,
  output logic        flush
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            frozen;

  logic            take_br;
  logic            redir;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] raw_target;
  logic [PC_W-1:0] load_target;
  logic [PC_W-1:0] pc_inc;
  logic            bad_target;

  // Request decode and target selection; a register jump outranks a branch.
  always_comb begin
    take_br    = branchValid & branchCond;
    redir      = jumpReg | take_br;
    br_target  = PC_W'(branchBase + shiftedOut);
    raw_target = jumpReg ? jumpTarget : br_target;
    pc_inc     = PC_W'(pc_q + STEP);
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign bad_target  = raw_target[0];
  assign load_target = raw_target;
  assign frozen      = misalign_q;
  assign misalign    = misalign_q;
`else
  assign bad_target  = 1'b0;
  assign load_target = raw_target & ~PC_W'(1);
  assign frozen      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: redirect > stall > increment; requests in the shadow are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH, HOLD: begin
        if (frozen) begin
          state_d = HOLD;
        end else if (redir) begin
          state_d = bad_target ? HOLD : REDIRECT;
        end else if (stall) begin
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      REDIRECT: begin
        state_d = stall ? HOLD : FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    if (!frozen) begin
      unique case (state_q)
        FETCH, HOLD: begin
          if (redir) begin
            flush_d = 1'b1;
            if (bad_target) begin
`ifdef PC_ALIGN_CHECK_EN
              misalign_d = 1'b1;
`endif
            end else begin
              pc_d = load_target;
            end
          end else if (!stall) begin
            pc_d = pc_inc;
          end
        end
        REDIRECT: begin
          if (!stall) begin
            pc_d = pc_inc;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  assign pc      = pc_q;
  assign flush   = flush_q;
  assign pcPlus2 = pc_inc;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vector table, corner sequences,
// and randomized traffic against a behavioural model (honours PC_ALIGN_CHECK_EN).
module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branchValid;
  logic        branchCond;
  logic [15:0] branchBase;
  logic [15:0] shiftedOut;
  logic        jumpReg;
  logic [15:0] jumpTarget;
  logic [15:0] pc;
  logic [15:0] pcPlus2;
  logic        flush;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  branch_pc_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branchValid (branchValid),
    .branchCond  (branchCond),
    .branchBase  (branchBase),
    .shiftedOut  (shiftedOut),
    .jumpReg     (jumpReg),
    .jumpTarget  (jumpTarget),
    .pc          (pc),
    .pcPlus2     (pcPlus2),
    .flush       (flush)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign    (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        stall;
    logic        bv;
    logic        bc;
    logic [15:0] base;
    logic [15:0] off;
    logic        jr;
    logic [15:0] jt;
    logic [15:0] exp_pc;
    logic        exp_flush;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state: pc, whether the next cycle is a redirect shadow, flags.
  logic [15:0] m_pc;
  logic        m_shadow;
  logic        m_flush;
  logic        m_mis;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(input logic s, input logic bv, input logic bc, input logic [15:0] b,
                       input logic [15:0] o, input logic jr, input logic [15:0] jt);
    stall = s; branchValid = bv; branchCond = bc;
    branchBase = b; shiftedOut = o; jumpReg = jr; jumpTarget = jt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string nm, input logic [15:0] epc, input logic ef, input logic em);
    chk({nm, ".pc"}, pc, epc);
    chk({nm, ".pcPlus2"}, pcPlus2, 16'(epc + 16'd2));
    chk({nm, ".flush"}, 16'(flush), 16'(ef));
`ifdef PC_ALIGN_CHECK_EN
    chk({nm, ".misalign"}, 16'(misalign), 16'(em));
`else
    if (em) $display("note: misalign expectation ignored without the check feature");
`endif
  endtask

  task automatic model_step(input logic s, input logic bv, input logic bc, input logic [15:0] b,
                            input logic [15:0] o, input logic jr, input logic [15:0] jt);
    logic [15:0] tgt;
    if (m_mis) begin
      m_flush  = 1'b0;
      m_shadow = 1'b0;
    end else if (!m_shadow && (jr || (bv && bc))) begin
      tgt     = jr ? jt : 16'(b + o);
      m_flush = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      if (tgt[0]) begin
        m_mis    = 1'b1;
        m_shadow = 1'b0;
      end else begin
        m_pc     = tgt;
        m_shadow = 1'b1;
      end
`else
      m_pc     = {tgt[15:1], 1'b0};
      m_shadow = 1'b1;
`endif
    end else begin
      m_flush  = 1'b0;
      m_shadow = 1'b0;
      if (!s) m_pc = 16'(m_pc + 16'd2);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_shadow = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
  endtask

  task automatic add(input logic s, input logic bv, input logic bc, input logic [15:0] b,
                     input logic [15:0] o, input logic jr, input logic [15:0] jt,
                     input logic [15:0] epc, input logic ef, input logic em);
    vec_t v;
    v.stall = s; v.bv = bv; v.bc = bc; v.base = b; v.off = o; v.jr = jr; v.jt = jt;
    v.exp_pc = epc; v.exp_flush = ef; v.exp_mis = em;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Directed vectors, one per clock edge, starting right after reset release.
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0002,0,0);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0004,0,0);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0006,0,0);
    add(0,1,1,16'h0006,16'h000A,0,16'h0000, 16'h0010,1,0);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0012,0,0);
    add(0,1,1,16'h0010,16'hFFF2,0,16'h0000, 16'h0002,1,0);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0004,0,0);
    add(0,1,1,16'hFFFE,16'h0004,0,16'h0000, 16'h0002,1,0);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0004,0,0);
    add(1,1,1,16'h0030,16'h0010,0,16'h0000, 16'h0040,1,0);
    add(1,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0040,0,0);
    add(1,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0040,0,0);
    add(1,1,0,16'h0000,16'h0100,0,16'h0000, 16'h0040,0,0);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0042,0,0);
    add(0,1,1,16'h0000,16'h0040,1,16'h0080, 16'h0080,1,0);
    add(0,1,1,16'h0000,16'h0200,0,16'h0000, 16'h0082,0,0);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0084,0,0);
`ifdef PC_ALIGN_CHECK_EN
    add(0,0,0,16'h0000,16'h0000,1,16'h0013, 16'h0084,1,1);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0084,0,1);
    add(0,1,1,16'h0000,16'h0100,0,16'h0000, 16'h0084,0,1);
`else
    add(0,0,0,16'h0000,16'h0000,1,16'h0013, 16'h0012,1,0);
    add(0,0,0,16'h0000,16'h0000,0,16'h0000, 16'h0014,0,0);
    add(0,1,1,16'h0000,16'h0100,0,16'h0000, 16'h0100,1,0);
`endif

    rst = 1'b1;
    drive(0,0,0,16'h0,16'h0,0,16'h0);
    tick();
    tick();
    chk_outs("reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].bv, vecs[i].bc, vecs[i].base, vecs[i].off, vecs[i].jr, vecs[i].jt);
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_flush, vecs[i].exp_mis);
    end

    // Wrap of pcPlus2 at the top of the address space.
    rst = 1'b1; #1; rst = 1'b0;
    drive(0,0,0,16'h0,16'h0,1,16'hFFFE);
    tick();
    chk("wrap.pc", pc, 16'hFFFE);
    chk("wrap.pcPlus2", pcPlus2, 16'h0000);
    drive(0,0,0,16'h0,16'h0,0,16'h0);
    tick();
    chk("wrap.next", pc, 16'h0000);

    // Asynchronous reset in the middle of the redirect shadow.
    drive(0,0,0,16'h0,16'h0,1,16'h0020);
    tick();
    chk_outs("arst.pre", 16'h0020, 1'b1, 1'b0);
    drive(0,0,0,16'h0,16'h0,0,16'h0);
    #2 rst = 1'b1;
    #1;
    chk_outs("arst.now", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_outs("arst.post", 16'h0002, 1'b0, 1'b0);

    // Randomized traffic against the model.
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      logic s, bv, bc, jr;
      logic [15:0] b, o, jt;
      if ($urandom_range(63) == 0) begin
        rst = 1'b1; #1;
        model_reset();
        chk_outs("rnd.rst", m_pc, m_flush, m_mis);
        rst = 1'b0;
      end
      s  = ($urandom_range(3) == 0);
      bv = ($urandom_range(3) == 0);
      bc = $urandom_range(1);
      jr = ($urandom_range(7) == 0);
      b  = 16'($urandom) & 16'hFFFE;
      o  = 16'($urandom) & 16'hFFFE;
      jt = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(15) == 0) jt = jt | 16'h0001;
      drive(s, bv, bc, b, o, jr, jt);
      model_step(s, bv, bc, b, o, jr, jt);
      tick();
      chk_outs($sformatf("rnd%0d", n), m_pc, m_flush, m_mis);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Fetch-stage program counter with branch/jump redirect for the 16-bit datapath. It sits directly downstream of the shift-left stage: it takes the word-aligned branch offset (`shiftedOut`), adds it to the branch instruction's PC+2, and loads the result into the PC when a taken branch resolves. It also handles stalls, register jumps, and a one-cycle pipeline flush after every redirect.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `PC_STEP`, default 2: sequential increment, in bytes.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC (downstream hazard).
- `branchValid`  in  1  a branch is resolving this cycle.
- `branchCond`  in  1  branch condition true; used only with `branchValid`.
- `branchBase`  in  16  PC+2 of the branch instruction.
- `shiftedOut`  in  16  sign-extended offset already shifted left by 1.
- `jumpReg`  in  1  register-jump request.
- `jumpTarget`  in  16  absolute register-jump target.
- `pc`  out  16  current fetch address.
- `pcPlus2`  out  16  `pc + PC_STEP`, combinational.
- `flush`  out  1  registered; kill the instruction fetched in the redirect shadow.
- `misalign`  out  1  sticky misaligned-target flag; present only under the macro.

## Operation
- Target computation:
  - Branch target = `branchBase + shiftedOut`, modulo 2^16.
  - Overflow is discarded, so negative offsets (two's complement) and wrap-around work naturally.
- Redirect requests:
  - `takeBr` = `branchValid & branchCond`.
  - `redir` = `jumpReg | takeBr`.
  - If both are set, `jumpReg` wins and the target is `jumpTarget`.
- States: `FETCH`, `HOLD`, `REDIRECT`; reset state is `FETCH`.
- `FETCH`:
  - `redir` → load target; go to `REDIRECT`.
  - Else `stall` → PC holds; go to `HOLD`.
  - Else `pc <= pc + PC_STEP`.
- `HOLD`:
  - Same priority as `FETCH`: `redir`, then `stall` (stay in `HOLD`), else increment and go to `FETCH`.
- `REDIRECT`:
  - `flush`=1 for exactly this cycle.
  - `branchValid` and `jumpReg` are ignored, because the requesting instruction's shadow is being flushed.
  - `stall` → hold the loaded target and go to `HOLD`, with `flush` already deasserted.
  - Else increment and go to `FETCH`.
- Priority: redirect > stall > increment. A branch arriving during a stall is never lost.
- `branchValid` with `branchCond`=0 behaves as if there were no request.

## Timing
- Reset values: `pc`=`RESET_PC`, `flush`=0, `misalign`=0, state `FETCH`.
- Reset acts immediately, regardless of `clk`. Reset during `REDIRECT` clears `flush` at once.
- Redirect latency is one edge: a request sampled at edge N gives `pc`=target and `flush`=1 after edge N.
- Two back-to-back redirect requests: the second, sampled in `REDIRECT`, is dropped.
- `pcPlus2` follows `pc` combinationally. When `pc`=16'hFFFE, `pcPlus2`=16'h0000.

## Configuration
- Macro: `PC_ALIGN_CHECK_EN`.
- Defined:
  - A redirect target with bit 0 = 1 is not loaded; `pc` holds.
  - `misalign` is set and stays at 1 until `rst`.
  - State goes to `HOLD` and `flush` is still pulsed for one cycle.
  - While `misalign`=1, `pc` stays frozen.
- Undefined:
  - The `misalign` port is absent.
  - Target bit 0 is forced to 0 and the load proceeds normally.

## Test plan
- Reset then run freely → `pc`=0000, 0002, 0004, 0006 on successive edges; `flush`=0 throughout.
- At `pc`=0006, `branchValid`=1, `branchCond`=1, `branchBase`=0006, `shiftedOut`=000A → `pc`=0010 with `flush`=1 for one cycle, then `pc`=0012 with `flush`=0.
- Negative offset and wrap:
  - `branchBase`=0010, `shiftedOut`=FFF2 → `pc`=0002.
  - `branchBase`=FFFE, `shiftedOut`=0004 → `pc`=0002.
- Same-cycle conflicts:
  - `stall`=1 with a taken branch to 0040 → `pc`=0040; the stall is ignored for that edge.
  - `branchCond`=0 → `pc` holds.
  - `jumpReg`=1 (`jumpTarget`=0080) together with a taken branch → `pc`=0080.
- Second taken branch asserted in `REDIRECT` → ignored; `pc` increments from the first target.
- `jumpTarget`=0013:
  - Macro on → `misalign`=1, `pc` unchanged, stays frozen until `rst`.
  - Macro off → `pc`=0012.
